// File: rtl/qp_mem_arbiter.sv
// qp_mem_arbiter
// Shares the single read/write port of the query-patch SRAM between the
// kd-tree search core and the wishbone debug path.
//
// Ports:
//   clk, rst_n         core clock, synchronous active-low reset
//   wbs_debug          1 = debug lock, only the wbs requester can be granted
//   core_req_* / wbs_req_*   request channel (valid/ready/we/addr/wdata)
//   core_rsp_* / wbs_rsp_*   read response channel (valid/ready/rdata)
//   mem_*0             SRAM port (active-low csb/web, 1-cycle read latency)
//   busy               any read pending or any response held
//
// Handshake: a transfer happens on a clock edge where valid & ready are both
// high. req_ready is combinational and may depend on req_valid; a requester
// holds valid/we/addr/wdata stable until accepted. A held response keeps
// rsp_valid and rsp_rdata stable until rsp_ready is seen.
module qp_mem_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 56
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wbs_debug,
    input  logic                  core_req_valid,
    output logic                  core_req_ready,
    input  logic                  core_req_we,
    input  logic [ADDR_WIDTH-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0] core_req_wdata,
    output logic                  core_rsp_valid,
    input  logic                  core_rsp_ready,
    output logic [DATA_WIDTH-1:0] core_rsp_rdata,
    input  logic                  wbs_req_valid,
    output logic                  wbs_req_ready,
    input  logic                  wbs_req_we,
    input  logic [ADDR_WIDTH-1:0] wbs_req_addr,
    input  logic [DATA_WIDTH-1:0] wbs_req_wdata,
    output logic                  wbs_rsp_valid,
    input  logic                  wbs_rsp_ready,
    output logic [DATA_WIDTH-1:0] wbs_rsp_rdata,
    output logic                  mem_csb0,
    output logic                  mem_web0,
    output logic [ADDR_WIDTH-1:0] mem_addr0,
    output logic [DATA_WIDTH-1:0] mem_wdata0,
    input  logic [DATA_WIDTH-1:0] mem_rdata0,
    output logic                  busy
);

    // Per-requester response slot.
    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,  // no read outstanding
        SLOT_PEND  = 2'd1,  // read issued last cycle, SRAM data arrives now
        SLOT_FULL  = 2'd2   // response held for the requester
    } slot_e;

    localparam logic GRANT_CORE = 1'b0;
    localparam logic GRANT_WBS  = 1'b1;

    slot_e                 core_slot_q, core_slot_d;
    slot_e                 wbs_slot_q, wbs_slot_d;
    logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
    logic [DATA_WIDTH-1:0] wbs_rdata_q, wbs_rdata_d;
    logic                  last_grant_q, last_grant_d;

    logic core_free, wbs_free;
    logic core_elig, wbs_elig;
    logic grant_core, grant_wbs;
    logic core_rd_issue, wbs_rd_issue;

    function automatic slot_e slot_next(input slot_e cur, input logic rd_issue,
                                        input logic rsp_ready);
        slot_e nxt;
        nxt = cur;
        case (cur)
            SLOT_EMPTY: if (rd_issue) nxt = SLOT_PEND;
            SLOT_PEND:  nxt = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready) nxt = rd_issue ? SLOT_PEND : SLOT_EMPTY;
            default:    nxt = SLOT_EMPTY;
        endcase
        return nxt;
    endfunction

    // Arbitration. A slot that is being drained this cycle can accept a new
    // read, which gives the FULL -> PEND back-to-back path. Reset gates all
    // grants so the SRAM stays idle while rst_n is low.
    always_comb begin
        core_free     = (core_slot_q == SLOT_EMPTY) ||
                        ((core_slot_q == SLOT_FULL) && core_rsp_ready);
        wbs_free      = (wbs_slot_q == SLOT_EMPTY) ||
                        ((wbs_slot_q == SLOT_FULL) && wbs_rsp_ready);
        core_elig     = rst_n && !wbs_debug && core_req_valid && (core_req_we || core_free);
        wbs_elig      = rst_n && wbs_req_valid && (wbs_req_we || wbs_free);
        grant_core    = core_elig && (!wbs_elig || (last_grant_q == GRANT_WBS));
        grant_wbs     = wbs_elig && !grant_core;
        core_rd_issue = grant_core && !core_req_we;
        wbs_rd_issue  = grant_wbs && !wbs_req_we;
    end

    // Next-state logic.
    always_comb begin
        core_slot_d  = slot_next(core_slot_q, core_rd_issue, core_rsp_ready);
        wbs_slot_d   = slot_next(wbs_slot_q, wbs_rd_issue, wbs_rsp_ready);
        core_rdata_d = (core_slot_q == SLOT_PEND) ? mem_rdata0 : core_rdata_q;
        wbs_rdata_d  = (wbs_slot_q == SLOT_PEND) ? mem_rdata0 : wbs_rdata_q;
        last_grant_d = last_grant_q;
        if (grant_core) begin
            last_grant_d = GRANT_CORE;
        end else if (grant_wbs) begin
            last_grant_d = GRANT_WBS;
        end
    end

    // State register. Reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_slot_q  <= SLOT_EMPTY;
            wbs_slot_q   <= SLOT_EMPTY;
            core_rdata_q <= '0;
            wbs_rdata_q  <= '0;
            last_grant_q <= GRANT_WBS;
        end else begin
            core_slot_q  <= core_slot_d;
            wbs_slot_q   <= wbs_slot_d;
            core_rdata_q <= core_rdata_d;
            wbs_rdata_q  <= wbs_rdata_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs. The SRAM port is driven straight from the granted request.
    always_comb begin
        core_req_ready = grant_core;
        wbs_req_ready  = grant_wbs;
        core_rsp_valid = (core_slot_q == SLOT_FULL);
        wbs_rsp_valid  = (wbs_slot_q == SLOT_FULL);
        core_rsp_rdata = core_rdata_q;
        wbs_rsp_rdata  = wbs_rdata_q;
        busy           = rst_n && ((core_slot_q != SLOT_EMPTY) || (wbs_slot_q != SLOT_EMPTY));
        mem_csb0       = 1'b1;
        mem_web0       = 1'b1;
        mem_addr0      = '0;
        mem_wdata0     = '0;
        if (grant_core) begin
            mem_csb0   = 1'b0;
            mem_web0   = !core_req_we;
            mem_addr0  = core_req_addr;
            mem_wdata0 = core_req_wdata;
        end else if (grant_wbs) begin
            mem_csb0   = 1'b0;
            mem_web0   = !wbs_req_we;
            mem_addr0  = wbs_req_addr;
            mem_wdata0 = wbs_req_wdata;
        end
    end

endmodule

// File: tb/tb_qp_mem_arbiter.sv
// Directed testbench for qp_mem_arbiter with a behavioural SRAM model.
module tb_qp_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 56;
  localparam logic [DW-1:0] D1 = 56'h00ABCDEF012345;
  localparam logic [DW-1:0] D2 = 56'h5A5A_1234_9876_01;
  localparam logic [DW-1:0] D3 = 56'h0F0F_0F0F_0F0F_0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, wbs_debug = 1'b0;
  logic core_req_valid = 1'b0, core_req_we = 1'b0, core_rsp_ready = 1'b0;
  logic [AW-1:0] core_req_addr = '0;
  logic [DW-1:0] core_req_wdata = '0;
  logic wbs_req_valid = 1'b0, wbs_req_we = 1'b0, wbs_rsp_ready = 1'b0;
  logic [AW-1:0] wbs_req_addr = '0;
  logic [DW-1:0] wbs_req_wdata = '0;
  logic core_req_ready, core_rsp_valid, wbs_req_ready, wbs_rsp_valid;
  logic [DW-1:0] core_rsp_rdata, wbs_rsp_rdata;
  logic mem_csb0, mem_web0, busy;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_wdata0;
  logic [DW-1:0] mem_rdata0 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  qp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wbs_debug(wbs_debug),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_rsp_valid(core_rsp_valid),
    .core_rsp_ready(core_rsp_ready), .core_rsp_rdata(core_rsp_rdata),
    .wbs_req_valid(wbs_req_valid), .wbs_req_ready(wbs_req_ready),
    .wbs_req_we(wbs_req_we), .wbs_req_addr(wbs_req_addr),
    .wbs_req_wdata(wbs_req_wdata), .wbs_rsp_valid(wbs_rsp_valid),
    .wbs_rsp_ready(wbs_rsp_ready), .wbs_rsp_rdata(wbs_rsp_rdata),
    .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
    .mem_wdata0(mem_wdata0), .mem_rdata0(mem_rdata0), .busy(busy)
  );

  // Preload pattern for the SRAM model.
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return 56'h00C0FFEE000000 | {{(DW-AW){1'b0}}, a};
  endfunction

  // SRAM model: registered read data, valid the cycle after issue.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram[i] = pat(AW'(i));
  end
  always @(posedge clk) begin
    if (!mem_csb0) begin
      if (!mem_web0) sram[mem_addr0] <= mem_wdata0;
      else mem_rdata0 <= sram[mem_addr0];
    end
  end

  // One cycle: advance past the active edge, then drive; look samples mid-cycle.
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic look;
    @(negedge clk);
  endtask

  task automatic do_reset;
    tick; rst_n = 1'b0;
    tick; tick; rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; core_req_valid = 1'b1; wbs_req_valid = 1'b1;
    tick; look;
    n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_core_ready: got %0b want 0", core_req_ready); end
    n_cmp++; if (wbs_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wbs_ready: got %0b want 0", wbs_req_ready); end
    n_cmp++; if ({mem_csb0, mem_web0} !== 2'b11) begin n_bad++; $display("FAIL rst_strobes: got %b want 11", {mem_csb0, mem_web0}); end
    n_cmp++; if (mem_addr0 !== '0 || mem_wdata0 !== '0) begin n_bad++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", mem_addr0, mem_wdata0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    tick; look;
    n_cmp++; if ({core_rsp_valid, wbs_rsp_valid} !== 2'b00) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", {core_rsp_valid, wbs_rsp_valid}); end
    n_cmp++; if (core_rsp_rdata !== '0 || wbs_rsp_rdata !== '0) begin n_bad++; $display("FAIL rst_rdata: got %h/%h want 0/0", core_rsp_rdata, wbs_rsp_rdata); end
    core_req_valid = 1'b0; wbs_req_valid = 1'b0;
    tick; rst_n = 1'b1; look;
    n_cmp++; if (mem_csb0 !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL idle: got csb=%0b busy=%0b want 1/0", mem_csb0, busy); end
    // Reset while a core read is pending drops it.
    tick; core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 9'h070; look;
    n_cmp++; if (core_req_ready !== 1'b1) begin n_bad++; $display("FAIL rstpend_accept: got %0b want 1", core_req_ready); end
    tick; core_req_valid = 1'b0; rst_n = 1'b0; look;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstpend_busy: got %0b want 0", busy); end
    tick; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look;
      n_cmp++; if (core_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rstpend_dropped[%0d]: got %0b want 0", i, core_rsp_valid); end
      tick;
    end
  endtask

  task automatic test_write_read;
    tick; core_rsp_ready = 1'b1; core_req_valid = 1'b1; core_req_we = 1'b1;
    core_req_addr = 9'h005; core_req_wdata = D1; look;
    n_cmp++; if (core_req_ready !== 1'b1) begin n_bad++; $display("FAIL wr_ready: got %0b want 1", core_req_ready); end
    n_cmp++; if ({mem_csb0, mem_web0} !== 2'b00) begin n_bad++; $display("FAIL wr_strobes: got %b want 00", {mem_csb0, mem_web0}); end
    n_cmp++; if (mem_addr0 !== 9'h005 || mem_wdata0 !== D1) begin n_bad++; $display("FAIL wr_bus: got %h/%h want 005/%h", mem_addr0, mem_wdata0, D1); end
    tick; core_req_we = 1'b0; look;
    n_cmp++; if ({core_req_ready, mem_csb0, mem_web0} !== 3'b101) begin n_bad++; $display("FAIL rd_issue: got %b want 101", {core_req_ready, mem_csb0, mem_web0}); end
    tick; core_req_valid = 1'b0; look;
    n_cmp++; if ({core_rsp_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL rd_pend: got valid/busy %b want 01", {core_rsp_valid, busy}); end
    tick; look;
    n_cmp++; if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== D1) begin n_bad++; $display("FAIL rd_data: got %0b/%h want 1/%h", core_rsp_valid, core_rsp_rdata, D1); end
    tick; look;
    n_cmp++; if ({core_rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rd_drained: got valid/busy %b want 00", {core_rsp_valid, busy}); end
  endtask

  task automatic test_round_robin;
    logic exp_core;
    do_reset;
    tick;
    core_rsp_ready = 1'b1; wbs_rsp_ready = 1'b1;
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 9'h010;
    wbs_req_valid = 1'b1; wbs_req_we = 1'b0; wbs_req_addr = 9'h020;
    for (int i = 0; i < 8; i++) begin
      look;
      exp_core = (i % 2 == 0);
      n_cmp++; if ({core_req_ready, wbs_req_ready} !== {exp_core, !exp_core}) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", i, {core_req_ready, wbs_req_ready}, {exp_core, !exp_core}); end
      n_cmp++; if (mem_csb0 !== 1'b0 || mem_addr0 !== (exp_core ? 9'h010 : 9'h020)) begin n_bad++; $display("FAIL rr_bus[%0d]: got csb=%0b addr=%h", i, mem_csb0, mem_addr0); end
      if (i >= 2) begin
        n_cmp++; if ({core_rsp_valid, wbs_rsp_valid} !== {exp_core, !exp_core}) begin n_bad++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, {core_rsp_valid, wbs_rsp_valid}, {exp_core, !exp_core}); end
        n_cmp++; if (exp_core ? (core_rsp_rdata !== pat(9'h010)) : (wbs_rsp_rdata !== pat(9'h020))) begin n_bad++; $display("FAIL rr_rdata[%0d]: got %h/%h", i, core_rsp_rdata, wbs_rsp_rdata); end
      end
      tick;
    end
    core_req_valid = 1'b0; wbs_req_valid = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_rsp_stall;
    tick; core_rsp_ready = 1'b0; wbs_rsp_ready = 1'b1;
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 9'h030; look;
    n_cmp++; if (core_req_ready !== 1'b1) begin n_bad++; $display("FAIL st_accept: got %0b want 1", core_req_ready); end
    tick; core_req_addr = 9'h031; look;
    n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL st_pend_block: got %0b want 0", core_req_ready); end
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i == 1) begin wbs_req_valid = 1'b1; wbs_req_we = 1'b0; wbs_req_addr = 9'h040; end
      if (i == 2) wbs_req_valid = 1'b0;
      look;
      n_cmp++; if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== pat(9'h030)) begin n_bad++; $display("FAIL st_hold[%0d]: got %0b/%h want 1/%h", i, core_rsp_valid, core_rsp_rdata, pat(9'h030)); end
      n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL st_block[%0d]: got %0b want 0", i, core_req_ready); end
      if (i == 1) begin
        n_cmp++; if (wbs_req_ready !== 1'b1) begin n_bad++; $display("FAIL st_wbs_accept: got %0b want 1", wbs_req_ready); end
      end
      if (i == 3) begin
        n_cmp++; if (wbs_rsp_valid !== 1'b1 || wbs_rsp_rdata !== pat(9'h040)) begin n_bad++; $display("FAIL st_wbs_rsp: got %0b/%h want 1/%h", wbs_rsp_valid, wbs_rsp_rdata, pat(9'h040)); end
      end
    end
    tick; core_rsp_ready = 1'b1; look;
    n_cmp++; if ({core_req_ready, core_rsp_valid} !== 2'b11) begin n_bad++; $display("FAIL st_b2b: got ready/valid %b want 11", {core_req_ready, core_rsp_valid}); end
    tick; core_req_valid = 1'b0; look;
    n_cmp++; if ({core_rsp_valid, busy} !== 2'b01) begin n_bad++; $display("FAIL st_b2b_pend: got %b want 01", {core_rsp_valid, busy}); end
    tick; look;
    n_cmp++; if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== pat(9'h031)) begin n_bad++; $display("FAIL st_b2b_data: got %0b/%h want 1/%h", core_rsp_valid, core_rsp_rdata, pat(9'h031)); end
    tick;
  endtask

  task automatic test_debug_lock;
    tick; wbs_debug = 1'b1; wbs_rsp_ready = 1'b1;
    core_req_valid = 1'b1; core_req_we = 1'b1; core_req_addr = 9'h050; core_req_wdata = D3;
    wbs_req_valid = 1'b1; wbs_req_we = 1'b1; wbs_req_addr = 9'h1FF; wbs_req_wdata = D2; look;
    n_cmp++; if ({core_req_ready, wbs_req_ready, mem_web0} !== 3'b010) begin n_bad++; $display("FAIL dbg_wr: got core/wbs/web %b want 010", {core_req_ready, wbs_req_ready, mem_web0}); end
    n_cmp++; if (mem_addr0 !== 9'h1FF || mem_wdata0 !== D2) begin n_bad++; $display("FAIL dbg_wr_bus: got %h/%h want 1ff/%h", mem_addr0, mem_wdata0, D2); end
    tick; wbs_req_we = 1'b0; look;
    n_cmp++; if ({core_req_ready, wbs_req_ready, mem_web0} !== 3'b011) begin n_bad++; $display("FAIL dbg_rd: got core/wbs/web %b want 011", {core_req_ready, wbs_req_ready, mem_web0}); end
    tick; wbs_req_valid = 1'b0; look;
    n_cmp++; if ({core_req_ready, mem_csb0} !== 2'b01) begin n_bad++; $display("FAIL dbg_idle: got ready/csb %b want 01", {core_req_ready, mem_csb0}); end
    tick; look;
    n_cmp++; if (core_req_ready !== 1'b0) begin n_bad++; $display("FAIL dbg_block: got %0b want 0", core_req_ready); end
    n_cmp++; if (wbs_rsp_valid !== 1'b1 || wbs_rsp_rdata !== D2) begin n_bad++; $display("FAIL dbg_rsp: got %0b/%h want 1/%h", wbs_rsp_valid, wbs_rsp_rdata, D2); end
    tick; wbs_debug = 1'b0; look;
    n_cmp++; if ({core_req_ready, mem_web0} !== 2'b10 || mem_addr0 !== 9'h050) begin n_bad++; $display("FAIL dbg_release: got ready/web %b addr %h want 10/050", {core_req_ready, mem_web0}, mem_addr0); end
    tick; core_req_valid = 1'b0;
  endtask

  task automatic test_debug_pending;
    tick; core_rsp_ready = 1'b1; core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 9'h060; look;
    n_cmp++; if (core_req_ready !== 1'b1) begin n_bad++; $display("FAIL dp_accept: got %0b want 1", core_req_ready); end
    tick; core_req_valid = 1'b0; wbs_debug = 1'b1; look;
    n_cmp++; if (core_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL dp_pend: got %0b want 0", core_rsp_valid); end
    tick; look;
    n_cmp++; if (core_rsp_valid !== 1'b1 || core_rsp_rdata !== pat(9'h060)) begin n_bad++; $display("FAIL dp_data: got %0b/%h want 1/%h", core_rsp_valid, core_rsp_rdata, pat(9'h060)); end
    tick; wbs_debug = 1'b0; look;
    n_cmp++; if ({core_rsp_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL dp_drained: got %b want 00", {core_rsp_valid, busy}); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_round_robin;
    test_rsp_stall;
    test_debug_lock;
    test_debug_pending;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
